// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase and monitor-state encodings, successor
// and lamp-pattern decode helpers used by both the controller and the monitor.
package tl_pkg;

  localparam logic [1:0] PH_NSG = 2'd0;
  localparam logic [1:0] PH_NSY = 2'd1;
  localparam logic [1:0] PH_EWG = 2'd2;
  localparam logic [1:0] PH_EWY = 2'd3;

  localparam logic [1:0] UNSYNC  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  typedef struct packed {
    logic       illegal;
    logic [1:0] phase;
  } tl_decode_t;

  function automatic logic [1:0] tl_successor(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_NSG;
    case (ph)
      PH_NSG: nxt = PH_NSY;
      PH_NSY: nxt = PH_EWG;
      PH_EWG: nxt = PH_EWY;
      PH_EWY: nxt = PH_NSG;
    endcase
    return nxt;
  endfunction

  // lamps = {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green}
  function automatic tl_decode_t tl_decode(input logic [5:0] lamps);
    tl_decode_t d;
    d.illegal = 1'b0;
    d.phase   = PH_NSG;
    case (lamps)
      6'b001_100: d.phase = PH_NSG;
      6'b010_100: d.phase = PH_NSY;
      6'b100_001: d.phase = PH_EWG;
      6'b100_010: d.phase = PH_EWY;
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter with clear, load-to-one and increment (priority in that order).
module tl_dwell_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = CW'(1);
    end else if (inc_i && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the six traffic-light lamp lines: phase decode, dwell measurement
// and pattern/sequence/timing error pulses. Optional sticky errors: TL_MON_STICKY_ERR_EN.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          NS_red,
  input  logic          NS_yellow,
  input  logic          NS_green,
  input  logic          EW_red,
  input  logic          EW_yellow,
  input  logic          EW_green,
  output logic [1:0]    phase,
  output logic          locked,
  output logic [CW-1:0] dwell,
  output logic          err_pattern,
  output logic          err_sequence,
  output logic          err_timing,
`ifdef TL_MON_STICKY_ERR_EN
  input  logic          err_clr,
  output logic [2:0]    err_sticky,
`endif
  output logic [15:0]   cycle_cnt
);

  localparam logic [CW-1:0] GreenExp  = CW'(GREEN_TIME + 1);
  localparam logic [CW-1:0] YellowExp = CW'(YELLOW_TIME + 1);

  tl_decode_t dec;
  assign dec = tl_decode({NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green});

  logic [1:0]  state_d, state_q;
  logic [1:0]  phase_d, phase_q;
  logic        rep_d, rep_q;
  logic [15:0] cnt_d, cnt_q;
  logic        errp_d, errp_q, errs_d, errs_q, errt_d, errt_q;
  logic        dw_clr, dw_load, dw_inc;
  logic [CW-1:0] dwell_q, exp_dwell;

  // Odd phase codes are the yellow phases.
  assign exp_dwell = phase_q[0] ? YellowExp : GreenExp;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    errp_d  = 1'b0;
    errs_d  = 1'b0;
    errt_d  = 1'b0;
    dw_clr  = 1'b0;
    dw_load = 1'b0;
    dw_inc  = 1'b0;
    if (dec.illegal) begin
      errp_d  = 1'b1;
      state_d = UNSYNC;
      dw_clr  = 1'b1;
    end else if (state_q == UNSYNC) begin
      state_d = ACQUIRE;
      phase_d = dec.phase;
      dw_load = 1'b1;
      rep_d   = 1'b0;
    end else if (dec.phase == phase_q) begin
      dw_inc = 1'b1;
      // Overstay is reported once, on the cycle the dwell passes the expected value.
      if ((state_q == LOCKED) && !rep_q && (dwell_q == exp_dwell)) begin
        errt_d = 1'b1;
        rep_d  = 1'b1;
      end
    end else if (dec.phase == tl_successor(phase_q)) begin
      if (state_q == LOCKED) begin
        if (!rep_q && (dwell_q != exp_dwell)) begin
          errt_d = 1'b1;
        end
        if (phase_q == PH_EWY) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      state_d = LOCKED;
      phase_d = dec.phase;
      dw_load = 1'b1;
      rep_d   = 1'b0;
    end else begin
      errs_d  = 1'b1;
      state_d = ACQUIRE;
      phase_d = dec.phase;
      dw_load = 1'b1;
      rep_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= UNSYNC;
      phase_q <= PH_NSG;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
      errp_q  <= 1'b0;
      errs_q  <= 1'b0;
      errt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      errp_q  <= errp_d;
      errs_q  <= errs_d;
      errt_q  <= errt_d;
    end
  end

  tl_dwell_counter #(
    .CW(CW)
  ) u_dwell (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (dw_clr),
    .load_i (dw_load),
    .inc_i  (dw_inc),
    .count_o(dwell_q)
  );

`ifdef TL_MON_STICKY_ERR_EN
  logic [2:0] sticky_d, sticky_q;

  // Set wins over a simultaneous clear.
  always_comb begin
    sticky_d = (sticky_q & {3{~err_clr}}) | {errt_d, errs_d, errp_d};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign err_sticky = sticky_q;
`endif

  assign phase        = phase_q;
  assign locked       = (state_q == LOCKED);
  assign dwell        = dwell_q;
  assign err_pattern  = errp_q;
  assign err_sequence = errs_q;
  assign err_timing   = errt_q;
  assign cycle_cnt    = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: cycle-level reference model plus
// directed lamp sequences with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam int GT   = 10;
  localparam int YT   = 3;
  localparam int CW   = 8;
  localparam int DMAX = (1 << CW) - 1;

  localparam logic [5:0] L_NSG  = 6'b001_100;
  localparam logic [5:0] L_NSY  = 6'b010_100;
  localparam logic [5:0] L_EWG  = 6'b100_001;
  localparam logic [5:0] L_EWY  = 6'b100_010;
  localparam logic [5:0] L_GG   = 6'b001_001;
  localparam logic [5:0] L_RR   = 6'b100_100;
  localparam logic [5:0] L_OFF  = 6'b000_000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    lamps = L_NSG;
  logic [1:0]    phase;
  logic          locked;
  logic [CW-1:0] dwell;
  logic          err_pattern, err_sequence, err_timing;
  logic [15:0]   cycle_cnt;
`ifdef TL_MON_STICKY_ERR_EN
  logic          clr = 1'b0;
  logic [2:0]    err_sticky;
  logic [2:0]    m_sticky;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_TIME (GT),
    .YELLOW_TIME(YT),
    .CW         (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .NS_red      (lamps[5]),
    .NS_yellow   (lamps[4]),
    .NS_green    (lamps[3]),
    .EW_red      (lamps[2]),
    .EW_yellow   (lamps[1]),
    .EW_green    (lamps[0]),
    .phase       (phase),
    .locked      (locked),
    .dwell       (dwell),
    .err_pattern (err_pattern),
    .err_sequence(err_sequence),
    .err_timing  (err_timing),
`ifdef TL_MON_STICKY_ERR_EN
    .err_clr     (clr),
    .err_sticky  (err_sticky),
`endif
    .cycle_cnt   (cycle_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: track the run of the currently held legal phase as plain integers.
  int m_phase, m_len, m_cnt;
  bit m_have, m_trusted, m_flagged;
  bit m_ep, m_es, m_et;

  function automatic int lamp_phase(input logic [5:0] l);
    logic [2:0] ns, ew;
    ns = l[5:3];
    ew = l[2:0];
    if (ew == 3'b100 && ns == 3'b001) return 0;
    if (ew == 3'b100 && ns == 3'b010) return 1;
    if (ns == 3'b100 && ew == 3'b001) return 2;
    if (ns == 3'b100 && ew == 3'b010) return 3;
    return -1;
  endfunction

  function automatic int expected_dwell(input int p);
    return (p % 2 == 0) ? GT + 1 : YT + 1;
  endfunction

  task automatic model_step(input logic [5:0] l, input logic r);
    int p;
    m_ep = 0; m_es = 0; m_et = 0;
    if (!r) begin
      m_phase = 0; m_len = 0; m_cnt = 0;
      m_have = 0; m_trusted = 0; m_flagged = 0;
      return;
    end
    p = lamp_phase(l);
    if (p < 0) begin
      m_ep = 1; m_have = 0; m_trusted = 0; m_len = 0;
    end else if (!m_have) begin
      m_have = 1; m_trusted = 0; m_phase = p; m_len = 1; m_flagged = 0;
    end else if (p == m_phase) begin
      m_len++;
      if (m_trusted && !m_flagged && m_len == expected_dwell(m_phase) + 1) begin
        m_et = 1; m_flagged = 1;
      end
    end else if (p == (m_phase + 1) % 4) begin
      if (m_trusted && !m_flagged && m_len != expected_dwell(m_phase)) m_et = 1;
      if (m_trusted && m_phase == 3) m_cnt++;
      m_trusted = 1; m_phase = p; m_len = 1; m_flagged = 0;
    end else begin
      m_es = 1; m_trusted = 0; m_phase = p; m_len = 1; m_flagged = 0;
    end
  endtask

  // Compare process: sample inputs at the edge, advance the model, check just after.
  always begin
    logic [5:0] s_l;
    logic       s_r;
    @(posedge clk);
    s_l = lamps;
    s_r = rst;
`ifdef TL_MON_STICKY_ERR_EN
    begin
      logic s_c;
      s_c = clr;
      model_step(s_l, s_r);
      if (!s_r) m_sticky = 3'b000;
      else m_sticky = (m_sticky & {3{~s_c}}) | {m_et, m_es, m_ep};
    end
`else
    model_step(s_l, s_r);
`endif
    #1;
    chk("phase", int'(phase), m_phase);
    chk("locked", int'(locked), int'(m_trusted));
    chk("dwell", int'(dwell), (m_len > DMAX) ? DMAX : m_len);
    chk("err_pattern", int'(err_pattern), int'(m_ep));
    chk("err_sequence", int'(err_sequence), int'(m_es));
    chk("err_timing", int'(err_timing), int'(m_et));
    chk("cycle_cnt", int'(cycle_cnt), m_cnt % 65536);
`ifdef TL_MON_STICKY_ERR_EN
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
`endif
  end

  task automatic step(input logic [5:0] l);
    @(negedge clk);
    lamps = l;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  task automatic round_after_nsg();
    hold(L_NSY, YT + 1);
    hold(L_EWG, GT + 1);
    hold(L_EWY, YT + 1);
  endtask

  initial begin
    hold(L_NSG, 3);
    chk("rst_phase", int'(phase), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_dwell", int'(dwell), 0);
    chk("rst_cnt", int'(cycle_cnt), 0);

    // Nominal controller sequence.
    rst = 1'b1;
    hold(L_NSG, 11);
    chk("acq_dwell11", int'(dwell), 11);
    chk("acq_unlocked", int'(locked), 0);
    step(L_NSY);
    chk("lock_on_nsy", int'(locked), 1);
    hold(L_NSY, 3);
    chk("yellow_dwell4", int'(dwell), 4);
    hold(L_EWG, 11);
    hold(L_EWY, 4);
    step(L_NSG);
    chk("cnt1", int'(cycle_cnt), 1);
    hold(L_NSG, 10);
    round_after_nsg();
    step(L_NSG);
    chk("cnt2", int'(cycle_cnt), 2);
    hold(L_NSG, 10);
    round_after_nsg();
    step(L_NSG);

    // Short green: flagged at the transition.
    hold(L_NSG, 8);
    step(L_NSY);
    chk("short_green_et", int'(err_timing), 1);
    hold(L_NSY, 3);
    hold(L_EWG, 11);
    hold(L_EWY, 4);

    // Long yellow: flagged when dwell reaches 5, not at the transition.
    hold(L_NSG, 11);
    hold(L_NSY, 4);
    chk("ly_no_et_at4", int'(err_timing), 0);
    step(L_NSY);
    chk("ly_dwell5", int'(dwell), 5);
    chk("ly_et_at5", int'(err_timing), 1);
    step(L_NSY);
    chk("ly_et_once", int'(err_timing), 0);
    step(L_EWG);
    chk("ly_no_et_trans", int'(err_timing), 0);
    hold(L_EWG, 10);
    hold(L_EWY, 4);

    // Out-of-order jump then relock.
    hold(L_NSG, 5);
    step(L_EWG);
    chk("seq_err", int'(err_sequence), 1);
    chk("seq_unlock", int'(locked), 0);
    hold(L_EWG, 10);
    step(L_EWY);
    chk("relock", int'(locked), 1);
    chk("relock_no_et", int'(err_timing), 0);
    hold(L_EWY, 3);
    hold(L_NSG, 11);

    // Illegal patterns.
    step(L_GG);
    chk("pat1_err", int'(err_pattern), 1);
    chk("pat1_unlock", int'(locked), 0);
    chk("pat1_dwell", int'(dwell), 0);
    step(L_GG);
    chk("pat2_err", int'(err_pattern), 1);
    step(L_RR);
    chk("allred_err", int'(err_pattern), 1);
    step(L_OFF);
    chk("alloff_err", int'(err_pattern), 1);
    chk("pat_phase_held", int'(phase), 0);
    step(L_NSG);
    chk("after_pat_no_es", int'(err_sequence), 0);
    chk("after_pat_dwell", int'(dwell), 1);

    // Dwell saturation while acquiring.
    hold(L_NSG, 299);
    chk("dwell_sat", int'(dwell), DMAX);

    // Reset mid-phase; first phase afterwards is not timing-checked.
    rst = 1'b0;
    step(L_NSG);
    chk("midrst_dwell", int'(dwell), 0);
    chk("midrst_locked", int'(locked), 0);
    rst = 1'b1;
    hold(L_NSY, 2);
    step(L_EWG);
    chk("postrst_lock", int'(locked), 1);
    chk("postrst_no_et", int'(err_timing), 0);
    hold(L_EWG, 2);
    step(L_EWY);
    chk("short_ewg_et", int'(err_timing), 1);

`ifdef TL_MON_STICKY_ERR_EN
    chk("sticky_t", int'(err_sticky), 3'b100);
    clr = 1'b1;
    step(L_GG);
    chk("sticky_set_wins", int'(err_sticky), 3'b001);
    clr = 1'b0;
    step(L_EWY);
    chk("sticky_hold", int'(err_sticky), 3'b001);
    clr = 1'b1;
    step(L_EWY);
    chk("sticky_clear", int'(err_sticky), 3'b000);
    clr = 1'b0;
`endif

    step(L_EWY);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
